// File: rtl/ex_muldiv_unit.sv
// EX-stage multiply/divide unit holding the architectural HI/LO registers.
// MULT/DIV results are computed when the op is accepted and committed after a fixed latency.
module ex_muldiv_unit #(
   parameter int unsigned MUL_CYCLES = 5,
   parameter int unsigned DIV_CYCLES = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        kill,
   output logic        busy,
   output logic        md_stall,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [2:0] {
      OP_NONE  = 3'd0,
      OP_MULT  = 3'd1,
      OP_MULTU = 3'd2,
      OP_DIV   = 3'd3,
      OP_DIVU  = 3'd4,
      OP_MTHI  = 3'd5,
      OP_MTLO  = 3'd6,
      OP_RSVD  = 3'd7
   } md_op_e;

   typedef enum logic {
      S_IDLE,
      S_RUN
   } state_e;

   localparam logic [3:0] MUL_LAST = 4'(MUL_CYCLES - 1);
   localparam logic [3:0] DIV_LAST = 4'(DIV_CYCLES - 1);

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        busy_q, busy_d;
   logic [31:0] res_hi_q, res_hi_d;
   logic [31:0] res_lo_q, res_lo_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   md_op_e      op_e;
   logic        is_mul, is_div, is_md, accept;

   assign op_e   = md_op_e'(op);
   assign is_mul = (op_e == OP_MULT) || (op_e == OP_MULTU);
   assign is_div = (op_e == OP_DIV)  || (op_e == OP_DIVU);
   assign is_md  = is_mul || is_div;
   assign accept = start && !kill && (state_q == S_IDLE) &&
                   (is_md || (op_e == OP_MTHI) || (op_e == OP_MTLO));

   // Sign/zero extension to 64 bits makes the low 64 product bits exact for both MULT and MULTU.
   logic [63:0] a_ext, b_ext, product;
   assign a_ext   = (op_e == OP_MULT) ? {{32{a[31]}}, a} : {32'd0, a};
   assign b_ext   = (op_e == OP_MULT) ? {{32{b[31]}}, b} : {32'd0, b};
   assign product = a_ext * b_ext;

   // Signed divide via magnitudes; this also yields the 8000_0000 / FFFF_FFFF overflow result.
   logic        a_neg, b_neg, div_by_zero;
   logic [31:0] a_mag, b_mag, q_mag, r_mag, quot, rem;
   assign a_neg       = (op_e == OP_DIV) && a[31];
   assign b_neg       = (op_e == OP_DIV) && b[31];
   assign a_mag       = a_neg ? (32'd0 - a) : a;
   assign b_mag       = b_neg ? (32'd0 - b) : b;
   assign div_by_zero = (b == '0);

   always_comb begin
      q_mag = '0;
      r_mag = '0;
      if (!div_by_zero) begin
         q_mag = a_mag / b_mag;
         r_mag = a_mag % b_mag;
      end
      quot = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
      rem  = a_neg ? (32'd0 - r_mag) : r_mag;
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      res_hi_d = res_hi_q;
      res_lo_d = res_lo_q;
      hi_d     = hi_q;
      lo_d     = lo_q;

      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (op_e == OP_MTHI) begin
                  hi_d = a;
               end else if (op_e == OP_MTLO) begin
                  lo_d = a;
               end else begin
                  state_d = S_RUN;
                  busy_d  = 1'b1;
                  if (is_mul) begin
                     cnt_d    = MUL_LAST;
                     res_hi_d = product[63:32];
                     res_lo_d = product[31:0];
                  end else begin
                     cnt_d = DIV_LAST;
                     if (div_by_zero) begin
                        res_hi_d = a;
                        res_lo_d = '1;
                     end else begin
                        res_hi_d = rem;
                        res_lo_d = quot;
                     end
                  end
               end
            end
         end
         S_RUN: begin
            if (cnt_q == '0) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
               hi_d    = res_hi_q;
               lo_d    = res_lo_q;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         res_hi_q <= '0;
         res_lo_q <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         res_hi_q <= res_hi_d;
         res_lo_q <= res_lo_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

   assign busy     = busy_q;
   assign md_stall = busy_q || (start && is_md);
   assign hi       = hi_q;
   assign lo       = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit: directed and randomized ops against an arithmetic reference model.
module tb_ex_muldiv_unit;

   localparam int MUL_N = 5;
   localparam int DIV_N = 10;

   logic        clk, rst_n, start, kill, busy, md_stall;
   logic [2:0]  op;
   logic [31:0] a, b, hi, lo;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_hi, exp_lo;

   ex_muldiv_unit #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .kill(kill),
      .busy(busy), .md_stall(md_stall), .hi(hi), .lo(lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] ref_md(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      longint          sp;
      longint unsigned up;
      int              q, r;
      case (o)
         3'd1: begin sp = longint'($signed(x)) * longint'($signed(y)); return sp; end
         3'd2: begin up = {32'd0, x} * {32'd0, y}; return up; end
         3'd3: begin
            if (y == 32'd0) return {x, 32'hFFFF_FFFF};
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
            q = $signed(x) / $signed(y);
            r = $signed(x) % $signed(y);
            return {r, q};
         end
         3'd4: begin
            if (y == 32'd0) return {x, 32'hFFFF_FFFF};
            return {x % y, x / y};
         end
         default: return 64'd0;
      endcase
   endfunction

   function automatic int ref_lat(input logic [2:0] o);
      return (o == 3'd1 || o == 3'd2) ? MUL_N : DIV_N;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents one MD op for a single cycle and observes it to completion.
   task automatic do_md_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                           output logic stall0, output int ncyc, output int stall_drop,
                           output int early, output logic [31:0] h, output logic [31:0] l);
      logic [31:0] h0, l0;
      h0 = hi; l0 = lo;
      ncyc = 0; stall_drop = 0; early = 0;
      start = 1'b1; op = o; a = x; b = y; kill = 1'b0;
      #1 stall0 = md_stall;
      step();
      start = 1'b0; op = 3'd0; a = $urandom; b = $urandom;
      while (busy === 1'b1 && ncyc < 40) begin
         if (md_stall !== 1'b1) stall_drop++;
         if (hi !== h0 || lo !== l0) early++;
         ncyc++;
         step();
      end
      h = hi; l = lo;
   endtask

   task automatic run_and_check(input string name, input logic [2:0] o,
                                input logic [31:0] x, input logic [31:0] y);
      logic        s0;
      int          n, sd, ec;
      logic [31:0] h, l;
      logic [63:0] r;
      r = ref_md(o, x, y);
      do_md_op(o, x, y, s0, n, sd, ec, h, l);
      checks++;
      if (s0 !== 1'b1) begin errors++; $display("FAIL %s stall_at_start got=%b exp=1", name, s0); end
      checks++;
      if (n != ref_lat(o)) begin errors++; $display("FAIL %s busy_cycles got=%0d exp=%0d", name, n, ref_lat(o)); end
      checks++;
      if (sd != 0 || ec != 0) begin errors++; $display("FAIL %s stall_drops=%0d early_hilo_changes=%0d exp=0/0", name, sd, ec); end
      checks++;
      if (h !== r[63:32] || l !== r[31:0]) begin
         errors++;
         $display("FAIL %s result op=%0d a=%h b=%h got hi=%h lo=%h exp hi=%h lo=%h", name, o, x, y, h, l, r[63:32], r[31:0]);
      end
      exp_hi = r[63:32]; exp_lo = r[31:0];
   endtask

   task automatic mt(input logic [2:0] o, input logic [31:0] x);
      start = 1'b1; op = o; a = x; kill = 1'b0;
      step();
      start = 1'b0; op = 3'd0;
      if (o == 3'd5) exp_hi = x; else exp_lo = x;
   endtask

   task automatic test_reset();
      logic s0;
      int   n, sd, ec;
      logic [31:0] h, l;
      rst_n = 1'b0; start = 1'b0; kill = 1'b0; op = 3'd0; a = '0; b = '0;
      #1;
      checks++;
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || md_stall !== 1'b0) begin
         errors++; $display("FAIL reset_init busy=%b hi=%h lo=%h stall=%b exp 0/0/0/0", busy, hi, lo, md_stall);
      end
      @(negedge clk); rst_n = 1'b1;
      step();
      mt(3'd5, 32'hA5A5_0001);
      mt(3'd6, 32'h5A5A_0002);
      start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
      step();
      start = 1'b0; op = 3'd0;
      step(); step();
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
         errors++; $display("FAIL reset_mid_div busy=%b hi=%h lo=%h exp 0/0/0", busy, hi, lo);
      end
      @(negedge clk); rst_n = 1'b1;
      for (int i = 0; i < DIV_N + 3; i++) step();
      checks++;
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
         errors++; $display("FAIL reset_release busy=%b hi=%h lo=%h exp 0/0/0", busy, hi, lo);
      end
      exp_hi = '0; exp_lo = '0;
      // suppress unused-output warnings for the helper outputs in this task
      s0 = 1'b0; n = 0; sd = 0; ec = 0; h = '0; l = '0;
   endtask

   task automatic test_directed();
      run_and_check("mult_neg",   3'd1, 32'hFFFF_FFFD, 32'd7);
      run_and_check("multu_big",  3'd2, 32'hFFFF_FFFD, 32'd7);
      run_and_check("div_neg",    3'd3, 32'hFFFF_FFF9, 32'd2);
      run_and_check("divu_small", 3'd4, 32'd7,         32'd2);
      run_and_check("divu_zero",  3'd4, 32'h0000_1234, 32'd0);
      run_and_check("div_zero",   3'd3, 32'h8765_4321, 32'd0);
      run_and_check("div_ovf",    3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
      run_and_check("div_rneg",   3'd3, 32'd7,         32'hFFFF_FFFE);
   endtask

   task automatic test_kill();
      start = 1'b1; op = 3'd1; a = 32'd3; b = 32'd9; kill = 1'b1;
      #1;
      checks++;
      if (md_stall !== 1'b1) begin errors++; $display("FAIL kill_stall got=%b exp=1", md_stall); end
      step();
      op = 3'd5; a = 32'hDEAD_BEEF;
      step();
      start = 1'b0; kill = 1'b0; op = 3'd0;
      checks++;
      if (busy !== 1'b0 || hi !== exp_hi || lo !== exp_lo) begin
         errors++; $display("FAIL kill_ignored busy=%b hi=%h lo=%h exp busy=0 hi=%h lo=%h", busy, hi, lo, exp_hi, exp_lo);
      end
   endtask

   task automatic test_start_while_busy();
      logic [63:0] r;
      int n, sd;
      r = ref_md(3'd1, 32'h0001_0003, 32'hFFFF_0005);
      start = 1'b1; op = 3'd1; a = 32'h0001_0003; b = 32'hFFFF_0005;
      step();
      op = 3'd4; a = 32'd1000; b = 32'd3;
      n = 0; sd = 0;
      while (busy === 1'b1 && n < 40) begin
         if (md_stall !== 1'b1) sd++;
         n++;
         step();
      end
      start = 1'b0; op = 3'd0;
      checks++;
      if (n != MUL_N || sd != 0) begin errors++; $display("FAIL busy_start_lat cycles=%0d stall_drops=%0d exp %0d/0", n, sd, MUL_N); end
      checks++;
      if (hi !== r[63:32] || lo !== r[31:0]) begin
         errors++; $display("FAIL busy_start_result hi=%h lo=%h exp hi=%h lo=%h", hi, lo, r[63:32], r[31:0]);
      end
      step();
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL busy_start_ignored busy=%b exp=0", busy); end
      exp_hi = r[63:32]; exp_lo = r[31:0];
   endtask

   task automatic test_mtlo();
      start = 1'b1; op = 3'd6; a = 32'd55;
      #1;
      checks++;
      if (md_stall !== 1'b0) begin errors++; $display("FAIL mtlo_stall got=%b exp=0", md_stall); end
      step();
      start = 1'b0; op = 3'd0;
      checks++;
      if (lo !== 32'd55 || hi !== exp_hi || busy !== 1'b0) begin
         errors++; $display("FAIL mtlo lo=%h hi=%h busy=%b exp lo=00000037 hi=%h busy=0", lo, hi, busy, exp_hi);
      end
      exp_lo = 32'd55;
   endtask

   task automatic test_back_to_back();
      logic [63:0] r;
      r = ref_md(3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
      start = 1'b1; op = 3'd1; a = 32'h1234_5678; b = 32'h9ABC_DEF0;
      step();
      start = 1'b0; op = 3'd0;
      for (int i = 0; i < MUL_N - 1; i++) step();
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL b2b_last_busy busy=%b exp=1", busy); end
      start = 1'b1; op = 3'd5; a = 32'hCAFE_F00D;
      step();
      checks++;
      if (busy !== 1'b0 || hi !== r[63:32] || lo !== r[31:0]) begin
         errors++; $display("FAIL b2b_commit busy=%b hi=%h lo=%h exp busy=0 hi=%h lo=%h", busy, hi, lo, r[63:32], r[31:0]);
      end
      step();
      start = 1'b0; op = 3'd0;
      checks++;
      if (hi !== 32'hCAFE_F00D || lo !== r[31:0]) begin
         errors++; $display("FAIL b2b_mthi hi=%h lo=%h exp hi=cafef00d lo=%h", hi, lo, r[31:0]);
      end
      exp_hi = 32'hCAFE_F00D; exp_lo = r[31:0];
   endtask

   task automatic test_random();
      logic [2:0]  o;
      logic [31:0] x, y;
      for (int i = 0; i < 40; i++) begin
         o = 3'($urandom_range(1, 6));
         x = $urandom;
         y = $urandom;
         case ($urandom_range(0, 7))
            0: y = 32'd0;
            1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
            2: y = 32'($urandom_range(1, 9));
            default: ;
         endcase
         if (o == 3'd5 || o == 3'd6) begin
            mt(o, x);
            checks++;
            if (hi !== exp_hi || lo !== exp_lo || busy !== 1'b0) begin
               errors++; $display("FAIL rand_mt op=%0d hi=%h lo=%h busy=%b exp hi=%h lo=%h busy=0", o, hi, lo, busy, exp_hi, exp_lo);
            end
         end else begin
            run_and_check("rand", o, x, y);
         end
      end
   endtask

   initial begin
      exp_hi = '0; exp_lo = '0;
      test_reset();
      test_directed();
      test_kill();
      test_start_while_busy();
      test_mtlo();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
